pointconv_feeder: RTL and testbench
===================================

// Module: pointconv_feeder
// PURPOSE
//  Producer side of the point-conv input interface: walks a sparse activation store map by map and
//  delivers (value, position) beats of up to LANES entries to the point-conv engine, waiting on its rdy.
//  Drives inmap index changes, which trigger the engine's weight reload, and flags layer end via layer_done.
//  Sits between the sparse activation SRAM and the point-conv engine, one instance per conv layer pipe.
// PARAMETERS
//  LANES   8   entries per beat; must match engine indata width
//  DW      32  value / position width
//  AW      12  entry-memory address width
//  MAPW    5   input-map index width
//  NVW     6   beat entry-count width (numOfInVals)
// PORTS
//  clk            in   1           clock, all state on rising edge
//  reset_n        in   1           asynchronous, active-low reset
//  start          in   1           1-cycle pulse: begin layer; ignored while busy
//  num_inmaps     in   MAPW+1      input maps in layer (0..32)
//  cnt_addr       out  MAPW        count-table read address (= map index)
//  cnt_data       in   AW          nonzero entries in map; valid 1 cycle after cnt_addr
//  ent_addr       out  AW          entry-memory read address
//  ent_data       in   2*DW        {position, value}; valid 1 cycle after ent_addr
//  outdata        out  LANES*DW    packed values, lane i = bits [i*DW +: DW]
//  outposition    out  LANES*DW    packed positions, same lane order
//  inmap_out      out  MAPW        current input-map index
//  num_vals       out  NVW         valid lanes in current beat (1..LANES)
//  valid_out      out  1           1-cycle beat strobe
//  rdy_in         in   1           engine idle and weights loaded
//  layer_done     out  1           level; all maps delivered
//  busy           out  1           high from accepted start until layer_done
// BEHAVIOUR
//  Reset (async): all outputs 0; FSM IDLE; entry pointer 0; map counter 0.
//  FSM: IDLE -> CNT (drive cnt_addr=map, 1 cycle) -> CNTW (capture cnt_data as remaining).
//   CNTW: remaining==0 -> skip map (no inmap change, no beat) -> NEXT; else -> SWITCH.
//   SWITCH: inmap_out<=map; load 2-cycle guard; -> FETCH once guard expired.
//   FETCH: issue min(remaining,LANES) reads on consecutive cycles, ent_addr += 1 each;
//    lane k captured the cycle after its address; unused lanes driven 0.
//   ARM: wait for rdy_in==1 -> FIRE. FIRE: valid_out=1 exactly one cycle, num_vals=lanes filled,
//    remaining -= lanes, load 2-cycle guard -> HOLD.
//   HOLD: outdata/outposition/num_vals/inmap_out held stable (engine indexes lanes over many cycles);
//    after guard, wait rdy_in==1; remaining>0 -> FETCH, else -> NEXT.
//   NEXT: map+1; map==num_inmaps -> DONE, else -> CNT.
//   DONE: layer_done=1, busy=0; held until next start, which clears layer_done and restarts at map 0.
//  Guard exists because engine rdy lags inmap change / valid_in by one cycle; rdy_in never sampled
//   before guard expiry.
//  Entry pointer is cumulative across maps (maps stored back-to-back); reset to 0 on start.
//  Map 0 first beat: inmap_out already 0 at reset; SWITCH still runs (no glitch, value unchanged).
//  num_inmaps==0: start -> DONE next cycle, no reads, no beats.
//  cnt_data > 2^AW - pointer: address wraps modulo 2^AW, no error flag.
//  start while busy: ignored. start in DONE: accepted.
//  Per-beat latency from HOLD exit with rdy_in high: lanes+2 cycles to FIRE (full beat: 10).
//  Reset mid-operation: immediate return to reset state; in-flight read data discarded.
// STRUCTURE
//  Package pointconv_pkg: LANES/DW/MAPW/NVW constants, feeder_state_e enum, lane_t struct {pos,val}.
//  One sub-module: pointconv_lane_packer (lane write index, capture enable, zero fill, packing).
//  FSM, counters, guard timer in top.
// TESTING
//  1 map, cnt=3, entries v=1..3 p=10..12 -> one beat num_vals=3, lanes 3..7 = 0, then layer_done.
//  1 map, cnt=20 -> beats num_vals 8,8,4; ent_addr 0..19 contiguous; data stable while rdy_in low.
//  3 maps, cnts 5,0,9 -> inmap_out 0 then 2 (1 skipped); beats 5 | 8,1; ent_addr continues 5..13.
//  rdy_in held low 50 cycles after FIRE -> no second valid_out; outputs unchanged throughout.
//  num_inmaps=0, start -> layer_done within 2 cycles, zero valid_out; restart start -> layer_done reissued.
//  reset_n low mid-FETCH of map 1 -> all outputs 0 same cycle; start after release restarts at map 0, ent_addr 0.

Source files
------------

// File: rtl/pointconv_pkg.sv
// Shared constants, FSM encoding and lane record for the point-conv input feeder.
// Entry words arrive as {position, value}, which matches lane_t bit for bit.
package pointconv_pkg;

    localparam int LANES     = 8;
    localparam int DW        = 32;
    localparam int AW        = 12;
    localparam int MAPW      = 5;
    localparam int NVW       = 6;
    localparam int LANE_IDXW = $clog2(LANES);

    localparam logic [1:0] GUARD_CYCLES = 2'd2;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_CNT,
        ST_CNTW,
        ST_SWITCH,
        ST_FETCH,
        ST_ARM,
        ST_FIRE,
        ST_HOLD,
        ST_NEXT,
        ST_DONE
    } feeder_state_e;

    typedef struct packed {
        logic [DW-1:0] pos;
        logic [DW-1:0] val;
    } lane_t;

    // Entries carried by the next beat: min(remaining, LANES).
    function automatic logic [NVW-1:0] beat_lanes(input logic [AW-1:0] remaining);
        if (remaining >= AW'(LANES)) begin
            return NVW'(LANES);
        end
        return NVW'(remaining);
    endfunction

endpackage

// File: rtl/pointconv_lane_packer.sv
// Collects entry-memory read data into lanes; capture is one cycle after each issued read.
// No backpressure of its own: lanes change only on clear or capture, so they hold while the FSM waits.
module pointconv_lane_packer
    import pointconv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  clear,
    input  logic                  rd_issue,
    input  logic [2*DW-1:0]       ent_data,
    output logic [LANES*DW-1:0]   outdata,
    output logic [LANES*DW-1:0]   outposition
);

    lane_t                 lanes_q [LANES];
    logic                  cap_vld_q;
    logic [LANE_IDXW-1:0]  wr_idx_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cap_vld_q <= 1'b0;
            wr_idx_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                lanes_q[i] <= '0;
            end
        end else begin
            cap_vld_q <= rd_issue;
            // Clearing at beat start leaves the unused tail lanes at zero.
            if (clear) begin
                wr_idx_q <= '0;
                for (int i = 0; i < LANES; i++) begin
                    lanes_q[i] <= '0;
                end
            end else if (cap_vld_q) begin
                lanes_q[wr_idx_q] <= lane_t'(ent_data);
                wr_idx_q          <= wr_idx_q + LANE_IDXW'(1);
            end
        end
    end

    always_comb begin
        outdata     = '0;
        outposition = '0;
        for (int i = 0; i < LANES; i++) begin
            outdata[i*DW +: DW]     = lanes_q[i].val;
            outposition[i*DW +: DW] = lanes_q[i].pos;
        end
    end

endmodule

// File: rtl/pointconv_feeder.sv
// Walks the sparse activation store map by map, delivering beats of up to LANES entries; a beat fires lanes+2 cycles after rdy_in.
// Beat outputs hold until the engine re-asserts rdy_in, which is ignored for 2 cycles after each map switch or beat.
module pointconv_feeder
    import pointconv_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [MAPW:0]         num_inmaps,
    output logic [MAPW-1:0]       cnt_addr,
    input  logic [AW-1:0]         cnt_data,
    output logic [AW-1:0]         ent_addr,
    input  logic [2*DW-1:0]       ent_data,
    output logic [LANES*DW-1:0]   outdata,
    output logic [LANES*DW-1:0]   outposition,
    output logic [MAPW-1:0]       inmap_out,
    output logic [NVW-1:0]        num_vals,
    output logic                  valid_out,
    input  logic                  rdy_in,
    output logic                  layer_done,
    output logic                  busy
);

    localparam logic [MAPW:0] MAP_ONE = (MAPW+1)'(1);

    feeder_state_e    state_q, state_d;
    logic [MAPW:0]    map_q, num_maps_q;
    logic [AW-1:0]    remaining_q, ptr_q;
    logic [1:0]       guard_q;
    logic [NVW-1:0]   lanes_q, fetch_cnt_q;

    logic             guard_done, last_read, map_last;
    logic             start_acc, beat_start, rd_issue, fire_next;

    assign guard_done = (guard_q == '0);
    assign last_read  = (fetch_cnt_q == lanes_q - NVW'(1));
    assign map_last   = ((map_q + MAP_ONE) == num_maps_q);

    assign cnt_addr = map_q[MAPW-1:0];
    assign ent_addr = ptr_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d = (num_inmaps == '0) ? ST_DONE : ST_CNT;
                end
            end
            ST_CNT:    state_d = ST_CNTW;
            ST_CNTW:   state_d = (cnt_data == '0) ? ST_NEXT : ST_SWITCH;
            ST_SWITCH: if (guard_done) state_d = ST_FETCH;
            ST_FETCH:  if (last_read) state_d = ST_ARM;
            ST_ARM:    if (rdy_in) state_d = ST_FIRE;
            ST_FIRE:   state_d = ST_HOLD;
            ST_HOLD: begin
                if (guard_done && rdy_in) begin
                    state_d = (remaining_q != '0) ? ST_FETCH : ST_NEXT;
                end
            end
            ST_NEXT:   state_d = map_last ? ST_DONE : ST_CNT;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        valid_out  = (state_q == ST_FIRE);
        layer_done = (state_q == ST_DONE);
        busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
        start_acc  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
        rd_issue   = (state_q == ST_FETCH);
        beat_start = (state_d == ST_FETCH) && (state_q != ST_FETCH);
        fire_next  = (state_q == ST_ARM) && rdy_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            map_q       <= '0;
            num_maps_q  <= '0;
            remaining_q <= '0;
            ptr_q       <= '0;
            guard_q     <= '0;
            lanes_q     <= '0;
            fetch_cnt_q <= '0;
            inmap_out   <= '0;
            num_vals    <= '0;
        end else begin
            if (start_acc) begin
                map_q      <= '0;
                num_maps_q <= num_inmaps;
            end else if (state_q == ST_NEXT) begin
                map_q <= map_q + MAP_ONE;
            end

            if (state_q == ST_CNTW) begin
                remaining_q <= cnt_data;
            end else if (state_q == ST_FIRE) begin
                remaining_q <= remaining_q - AW'(lanes_q);
            end

            // Engine rdy lags inmap/valid changes, so it is not trusted until this runs out.
            if ((state_q == ST_CNTW) || (state_q == ST_FIRE)) begin
                guard_q <= GUARD_CYCLES;
            end else if (guard_q != '0) begin
                guard_q <= guard_q - 2'd1;
            end

            if (state_q == ST_SWITCH) begin
                inmap_out <= map_q[MAPW-1:0];
            end

            // Maps sit back to back, so the pointer only restarts on a new layer; it wraps modulo 2^AW.
            if (start_acc) begin
                ptr_q <= '0;
            end else if (rd_issue) begin
                ptr_q <= ptr_q + AW'(1);
            end

            if (beat_start) begin
                lanes_q     <= beat_lanes(remaining_q);
                fetch_cnt_q <= '0;
            end else if (rd_issue) begin
                fetch_cnt_q <= fetch_cnt_q + NVW'(1);
            end

            if (fire_next) begin
                num_vals <= lanes_q;
            end
        end
    end

    pointconv_lane_packer u_packer (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (beat_start),
        .rd_issue    (rd_issue),
        .ent_data    (ent_data),
        .outdata     (outdata),
        .outposition (outposition)
    );

endmodule

// File: tb/tb_pointconv_feeder.sv
// Bench for pointconv_feeder: count table and entry memory models, table-driven layers, scoreboarded beats.
// Entry word at address a is {pos = a+10, val = a+1}.
`timescale 1ns/1ps
module tb_pointconv_feeder;
    import pointconv_pkg::*;

    localparam int BUDGET = 3000;

    logic                 clk = 1'b0;
    logic                 reset_n = 1'b0;
    logic                 start = 1'b0;
    logic [MAPW:0]        num_inmaps = '0;
    logic [MAPW-1:0]      cnt_addr;
    logic [AW-1:0]        cnt_data;
    logic [AW-1:0]        ent_addr;
    logic [2*DW-1:0]      ent_data;
    logic [LANES*DW-1:0]  outdata, outposition;
    logic [MAPW-1:0]      inmap_out;
    logic [NVW-1:0]       num_vals;
    logic                 valid_out;
    logic                 rdy_in = 1'b1;
    logic                 layer_done;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        int                   nmaps;
        logic [3:0][AW-1:0]   cnt;
        int                   hold;
        bit                   restart;
        int                   exp_beats;
    } vec_t;

    typedef struct packed {
        int map;
        int n;
        int base;
        bit after_hold;
    } beat_t;

    vec_t        vecs [6];
    beat_t       sb [$];
    logic [AW-1:0] cnt_tab [32];

    always #5 clk = ~clk;

    pointconv_feeder dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_inmaps  (num_inmaps),
        .cnt_addr    (cnt_addr),
        .cnt_data    (cnt_data),
        .ent_addr    (ent_addr),
        .ent_data    (ent_data),
        .outdata     (outdata),
        .outposition (outposition),
        .inmap_out   (inmap_out),
        .num_vals    (num_vals),
        .valid_out   (valid_out),
        .rdy_in      (rdy_in),
        .layer_done  (layer_done),
        .busy        (busy)
    );

    function automatic logic [2*DW-1:0] ent_word(input logic [AW-1:0] a);
        logic [DW-1:0] v, p;
        v = DW'(a) + 32'd1;
        p = DW'(a) + 32'd10;
        return {p, v};
    endfunction

    always @(posedge clk) begin
        cnt_data <= cnt_tab[cnt_addr];
        ent_data <= ent_word(ent_addr);
    end

    function automatic vec_t mk(input int nm, input int c0, input int c1, input int c2, input int c3,
                                input int hold, input bit rs, input int eb);
        vec_t v;
        v.nmaps     = nm;
        v.cnt       = {AW'(c3), AW'(c2), AW'(c1), AW'(c0)};
        v.hold      = hold;
        v.restart   = rs;
        v.exp_beats = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ctrl"}, {cnt_addr, ent_addr, inmap_out, num_vals, valid_out, layer_done, busy}, '0);
        check({tag, "_outdata"}, outdata, '0);
        check({tag, "_outposition"}, outposition, '0);
    endtask

    task automatic run_case(input vec_t v);
        int ptr, cyc, beats, lat, stable_bad;
        beat_t e;
        logic [LANES*DW-1:0] ed, ep, snap_d, snap_p;
        logic [NVW+MAPW-1:0] snap_c;

        for (int m = 0; m < 32; m++) cnt_tab[m] = '0;
        for (int m = 0; m < 4; m++) cnt_tab[m] = v.cnt[m];

        // Expected beats: maps split into LANES-sized chunks, addresses cumulative from 0.
        ptr = 0;
        for (int m = 0; m < v.nmaps; m++) begin
            int c;
            bit first;
            c = int'(v.cnt[m]);
            first = 1'b1;
            while (c > 0) begin
                e.map = m;
                e.n = (c > LANES) ? LANES : c;
                e.base = ptr;
                e.after_hold = !first;
                sb.push_back(e);
                ptr += e.n;
                c -= e.n;
                first = 1'b0;
            end
        end

        num_inmaps = (MAPW+1)'(v.nmaps);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (v.nmaps == 0) check("zero_maps_done", {layer_done, busy}, 2'b10);
        else              check("start_clears_done", {layer_done, busy}, 2'b01);

        cyc = 0;
        beats = 0;
        lat = -1000;
        while (layer_done !== 1'b1 && cyc < BUDGET) begin
            if (valid_out === 1'b1) begin
                beats++;
                if (sb.size() == 0) begin
                    check("extra_beat", 1, 0);
                end else begin
                    e = sb.pop_front();
                    ed = '0;
                    ep = '0;
                    for (int k = 0; k < e.n; k++) begin
                        ed[k*DW +: DW] = DW'(e.base + k + 1);
                        ep[k*DW +: DW] = DW'(e.base + k + 10);
                    end
                    check("beat_nvals_map", {num_vals, inmap_out}, {NVW'(e.n), MAPW'(e.map)});
                    check("beat_outdata", outdata, ed);
                    check("beat_outposition", outposition, ep);
                    if (e.after_hold) check("beat_latency", lat, e.n + 2);
                end
                snap_d = outdata;
                snap_p = outposition;
                snap_c = {num_vals, inmap_out};
                rdy_in = 1'b0;
                stable_bad = 0;
                for (int k = 0; k < v.hold; k++) begin
                    start = (v.restart && k == 0);
                    @(negedge clk);
                    cyc++;
                    if (valid_out !== 1'b0 || outdata !== snap_d || outposition !== snap_p ||
                        {num_vals, inmap_out} !== snap_c) stable_bad++;
                end
                start = 1'b0;
                check("hold_stable", stable_bad, 0);
                rdy_in = 1'b1;
                lat = 0;
            end
            @(negedge clk);
            cyc++;
            lat++;
        end
        check("layer_done_reached", {layer_done, busy}, 2'b10);
        check("beat_count", beats, v.exp_beats);
        check("scoreboard_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic reset_mid_fetch();
        int cyc;
        for (int m = 0; m < 32; m++) cnt_tab[m] = '0;
        cnt_tab[0] = AW'(3);
        cnt_tab[1] = AW'(8);
        num_inmaps = (MAPW+1)'(2);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(ent_addr == AW'(5) && inmap_out == MAPW'(1)) && cyc < 300) begin
            @(negedge clk);
            cyc++;
        end
        check("map1_fetch_reached", (cyc < 300), 1);
        reset_n = 1'b0;
        #1;
        check_zero("reset_mid_fetch");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int m = 0; m < 32; m++) cnt_tab[m] = '0;
        vecs[0] = mk(0,  0, 0, 0, 0,  3, 1'b0, 0);
        vecs[1] = mk(1,  3, 0, 0, 0,  3, 1'b0, 1);
        vecs[2] = mk(1, 20, 0, 0, 0, 50, 1'b0, 3);
        vecs[3] = mk(3,  5, 0, 9, 0,  3, 1'b1, 3);
        vecs[4] = mk(0,  0, 0, 0, 0,  3, 1'b0, 0);
        vecs[5] = mk(4,  0, 8, 7, 1,  4, 1'b0, 3);

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        reset_n = 1'b1;
        @(negedge clk);
        check_zero("idle_after_reset");

        for (int i = 0; i < 6; i++) run_case(vecs[i]);

        reset_mid_fetch();
        run_case(mk(1, 2, 0, 0, 0, 3, 1'b0, 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
